// File: rtl/acc_mem_responder.sv
// Memory-side responder for the accumulator CPU: single-word read/write with a
// fixed access latency, one-cycle mem_ready acknowledge and mem_error flag.
//
//   state | meaning
//   ------+--------------------------------------------------
//   IDLE  | waiting for a request (not during the ack cycle)
//   BUSY  | request latched, latency countdown in progress
module acc_mem_responder #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    output logic              mem_error,
    output logic              busy
);

    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U  = DEPTH;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_rd_q, op_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] read_data_q;
    logic              mem_ready_q, mem_error_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic             accept, complete, in_range, illegal;
    logic             do_read, do_write, err;
    logic [IDX_W-1:0] idx;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                // the strobe still held during the ack cycle belongs to the finished access
                if (!mem_ready_q && (mem_read || mem_write)) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign idx      = addr_q[IDX_W-1:0];
    assign in_range = ({{(32-ADDR_W){1'b0}}, addr_q} < DEPTH_U);
    assign illegal  = op_rd_q & op_wr_q;
    assign do_read  = complete & op_rd_q & ~op_wr_q;
    assign do_write = complete & op_wr_q & ~op_rd_q & in_range;
    assign err      = complete & (illegal | ~in_range);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_rd_q <= 1'b0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_rd_q <= mem_read;
                op_wr_q <= mem_write;
                addr_q  <= address;
                wdata_q <= write_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data_q <= '0;
            mem_ready_q <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            mem_ready_q <= complete;
            mem_error_q <= err;
            if (do_read) begin
                read_data_q <= in_range ? mem[idx] : '0;
            end
        end
    end

    // Storage survives reset; an aborted access never reaches here since reset forces IDLE.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= wdata_q;
        end
    end

    assign read_data = read_data_q;
    assign mem_ready = mem_ready_q;
    assign mem_error = mem_error_q;
    assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_acc_mem_responder.sv
// Bench for acc_mem_responder: three parameterisations checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_acc_mem_responder;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_s   [NI];
    logic       wr_s   [NI];
    logic [11:0] addr_s[NI];
    logic [7:0] wd_s   [NI];
    logic [7:0] rdata_o[NI];
    logic       rdy_o  [NI];
    logic       err_o  [NI];
    logic       busy_o [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    acc_mem_responder #(.DATA_W(8), .ADDR_W(12), .DEPTH(4096), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
        .address(addr_s[0]), .write_data(wd_s[0]), .read_data(rdata_o[0]),
        .mem_ready(rdy_o[0]), .mem_error(err_o[0]), .busy(busy_o[0]));

    acc_mem_responder #(.DATA_W(8), .ADDR_W(12), .DEPTH(4096), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
        .address(addr_s[1]), .write_data(wd_s[1]), .read_data(rdata_o[1]),
        .mem_ready(rdy_o[1]), .mem_error(err_o[1]), .busy(busy_o[1]));

    acc_mem_responder #(.DATA_W(8), .ADDR_W(12), .DEPTH(256), .LATENCY(4)) u_dut2 (
        .clk(clk), .rst(rst), .mem_read(rd_s[2]), .mem_write(wr_s[2]),
        .address(addr_s[2]), .write_data(wd_s[2]), .read_data(rdata_o[2]),
        .mem_ready(rdy_o[2]), .mem_error(err_o[2]), .busy(busy_o[2]));

    function automatic int lat_of(input int i);
        case (i)
            0: return 2;
            1: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int dep_of(input int i);
        return (i == 2) ? 256 : 4096;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a request occupies the responder for LATENCY edges,
    // then its effect appears together with a one-cycle acknowledge.
    bit          m_pend  [NI];
    int          m_left  [NI];
    bit          m_rdy   [NI];
    bit          m_err   [NI];
    logic [7:0]  m_rd    [NI];
    bit          m_rd_ok [NI];
    bit          m_op_r  [NI];
    bit          m_op_w  [NI];
    logic [11:0] m_a     [NI];
    logic [7:0]  m_d     [NI];
    logic [7:0]  m_mem   [NI][4096];
    bit          m_known [NI][4096];
    bit          nr, ne;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                m_pend[i]  = 1'b0;
                m_left[i]  = 0;
                m_rdy[i]   = 1'b0;
                m_err[i]   = 1'b0;
                m_rd[i]    = 8'h00;
                m_rd_ok[i] = 1'b1;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                nr = 1'b0;
                ne = 1'b0;
                if (m_pend[i]) begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        m_pend[i] = 1'b0;
                        nr = 1'b1;
                        if (m_op_r[i] && m_op_w[i]) begin
                            ne = 1'b1;
                        end else if (int'(m_a[i]) >= dep_of(i)) begin
                            ne = 1'b1;
                            if (m_op_r[i]) begin
                                m_rd[i]    = 8'h00;
                                m_rd_ok[i] = 1'b1;
                            end
                        end else if (m_op_w[i]) begin
                            m_mem[i][m_a[i]]   = m_d[i];
                            m_known[i][m_a[i]] = 1'b1;
                        end else begin
                            m_rd[i]    = m_mem[i][m_a[i]];
                            m_rd_ok[i] = m_known[i][m_a[i]];
                        end
                    end
                end else if (!m_rdy[i] && (rd_s[i] || wr_s[i])) begin
                    m_pend[i] = 1'b1;
                    m_left[i] = lat_of(i);
                    m_op_r[i] = rd_s[i];
                    m_op_w[i] = wr_s[i];
                    m_a[i]    = addr_s[i];
                    m_d[i]    = wd_s[i];
                end
                m_rdy[i] = nr;
                m_err[i] = ne;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("model_ready_%0d", i), 32'(rdy_o[i]), 32'(m_rdy[i]));
            chk($sformatf("model_error_%0d", i), 32'(err_o[i]), 32'(m_err[i]));
            chk($sformatf("model_busy_%0d", i), 32'(busy_o[i]), 32'(m_pend[i]));
            if (m_rd_ok[i])
                chk($sformatf("model_rdata_%0d", i), 32'(rdata_o[i]), 32'(m_rd[i]));
        end
    end

    // Issue one request and wait for its ack; returns the error flag seen with it.
    task automatic req(input int i, input bit r, input bit w, input logic [11:0] a,
                       input logic [7:0] d, input bit hold, output bit e);
        int n, nb;
        @(negedge clk);
        rd_s[i] = r; wr_s[i] = w; addr_s[i] = a; wd_s[i] = d;
        n = 0; nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy_o[i]) nb++;
        end while (!rdy_o[i] && n < 40);
        chk($sformatf("ack_latency_%0d_%0h", i, a), 32'(n), 32'(lat_of(i) + 1));
        chk($sformatf("busy_cycles_%0d_%0h", i, a), 32'(nb), 32'(lat_of(i)));
        e = err_o[i];
        if (!hold) begin
            rd_s[i] = 1'b0; wr_s[i] = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit e;
        int n;
        for (int i = 0; i < NI; i++) begin
            rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = '0; wd_s[i] = '0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rdata", 32'(rdata_o[0]), 32'h0);
        chk("reset_ready", 32'(rdy_o[0]), 32'h0);
        chk("reset_error", 32'(err_o[0]), 32'h0);
        chk("reset_busy", 32'(busy_o[0]), 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // basic write then read
        req(0, 1'b0, 1'b1, 12'h005, 8'hA7, 1'b0, e);
        chk("t1_write_err", 32'(e), 32'h0);
        req(0, 1'b1, 1'b0, 12'h005, 8'h00, 1'b0, e);
        chk("t1_read_err", 32'(e), 32'h0);
        chk("t1_read_data", 32'(rdata_o[0]), 32'hA7);

        // held strobe: no re-acceptance during the ack cycle
        req(0, 1'b1, 1'b0, 12'h005, 8'h00, 1'b1, e);
        @(negedge clk);
        chk("t2_no_accept_ack_cycle_busy", 32'(busy_o[0]), 32'h0);
        chk("t2_single_pulse", 32'(rdy_o[0]), 32'h0);
        @(negedge clk);
        chk("t2_accept_after_ack", 32'(busy_o[0]), 32'h1);
        rd_s[0] = 1'b0;
        n = 0;
        while (!rdy_o[0] && n < 20) begin @(negedge clk); n++; end
        chk("t2_second_ack", 32'(rdy_o[0]), 32'h1);

        // both strobes: error, no access
        req(0, 1'b1, 1'b1, 12'h005, 8'h11, 1'b0, e);
        chk("t3_both_err", 32'(e), 32'h1);
        chk("t3_rdata_unchanged", 32'(rdata_o[0]), 32'hA7);
        req(0, 1'b1, 1'b0, 12'h005, 8'h00, 1'b0, e);
        chk("t3_mem_intact", 32'(rdata_o[0]), 32'hA7);

        // DEPTH=256 range checks
        req(2, 1'b0, 1'b1, 12'h000, 8'h11, 1'b0, e);
        req(2, 1'b1, 1'b0, 12'h100, 8'h00, 1'b0, e);
        chk("t4_oor_read_err", 32'(e), 32'h1);
        chk("t4_oor_read_data", 32'(rdata_o[2]), 32'h00);
        req(2, 1'b0, 1'b1, 12'h100, 8'h55, 1'b0, e);
        chk("t4_oor_write_err", 32'(e), 32'h1);
        req(2, 1'b0, 1'b1, 12'h0FF, 8'h66, 1'b0, e);
        chk("t4_last_write_err", 32'(e), 32'h0);
        req(2, 1'b1, 1'b0, 12'h0FF, 8'h00, 1'b0, e);
        chk("t4_last_read_err", 32'(e), 32'h0);
        chk("t4_last_read_data", 32'(rdata_o[2]), 32'h66);
        req(2, 1'b1, 1'b0, 12'h000, 8'h00, 1'b0, e);
        chk("t4_no_alias_write", 32'(rdata_o[2]), 32'h11);

        // reset mid-BUSY aborts the write
        req(0, 1'b0, 1'b1, 12'h010, 8'h99, 1'b0, e);
        @(negedge clk);
        wr_s[0] = 1'b1; addr_s[0] = 12'h010; wd_s[0] = 8'h3C;
        @(negedge clk);
        chk("t5_busy_before_reset", 32'(busy_o[0]), 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("t5_reset_busy", 32'(busy_o[0]), 32'h0);
        chk("t5_reset_ready", 32'(rdy_o[0]), 32'h0);
        chk("t5_reset_error", 32'(err_o[0]), 32'h0);
        chk("t5_reset_rdata", 32'(rdata_o[0]), 32'h0);
        wr_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (rdy_o[0]) n++;
        end
        chk("t5_no_ack_after_release", 32'(n), 32'h0);
        req(0, 1'b1, 1'b0, 12'h010, 8'h00, 1'b0, e);
        chk("t5_old_value_kept", 32'(rdata_o[0]), 32'h99);

        // LATENCY=1 at the top address
        req(1, 1'b0, 1'b1, 12'hFFF, 8'h5A, 1'b0, e);
        chk("t6_top_write_err", 32'(e), 32'h0);
        req(1, 1'b1, 1'b0, 12'hFFF, 8'h00, 1'b0, e);
        chk("t6_top_read_data", 32'(rdata_o[1]), 32'h5A);

        // LATENCY=4: address change and strobe drop mid-BUSY use the latched request
        req(2, 1'b0, 1'b1, 12'h020, 8'h77, 1'b0, e);
        req(2, 1'b0, 1'b1, 12'h021, 8'h88, 1'b0, e);
        @(negedge clk);
        rd_s[2] = 1'b1; addr_s[2] = 12'h020;
        @(negedge clk);
        rd_s[2] = 1'b0; addr_s[2] = 12'h021;
        n = 0;
        while (!rdy_o[2] && n < 20) begin @(negedge clk); n++; end
        chk("t6_dropped_strobe_ack", 32'(rdy_o[2]), 32'h1);
        chk("t6_latched_addr_data", 32'(rdata_o[2]), 32'h77);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
